fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage and sole driver of the 3-input 32-bit next-PC mux (mux_3input_32bit). It holds the PC and fetches from instruction memory over a req/ack handshake. It presents the three PC candidates and the mux select, and loads the mux output back into the PC. Its output is the IF/ID pipeline register consumed by decode.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, value driven on if_instr when invalid/reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request
imem_addr  out  32  fetch address (= pc)
imem_ack  in  1  one-cycle pulse, imem_rdata valid
imem_rdata  in  32  fetched instruction
branch_taken  in  1  redirect to branch_target (from EX)
branch_target  in  32  branch destination
jump_taken  in  1  redirect to jump_target
jump_target  in  32  jump destination
stall  in  1  decode hazard, hold IF/ID
flush  in  1  invalidate IF/ID and skid
pc_sel  out  2  mux Select: 0 = pc+4, 1 = branch/saved target, 2 = jump
pc_cands  out  96  mux inData: [31:0] = pc+4, [63:32] = branch or saved target, [95:64] = jump_target
next_pc  in  32  mux outData
if_valid  out  1  IF/ID holds a valid instruction
if_instr  out  32  IF/ID instruction
if_pc  out  32  IF/ID instruction address
if_pc_plus4  out  32  if_pc+4 (mod 2^32)

Behaviour:
- Reset (async, rst_n=0), effective on the next clock after release:
  - pc = RESET_PC; state = FETCH.
  - imem_req = 0 while in reset.
  - if_valid = 0; if_instr = NOP_INSTR; if_pc = 0; if_pc_plus4 = 0.
  - Skid and saved target are cleared.
- redirect = jump_taken | branch_taken. Jump has priority: pc_sel = 2 if jump_taken, else 1 if branch_taken, else 0. Exception: in DRAIN, pc_sel = 1 and pc_cands[63:32] = saved_target.
- imem_req = 1 in FETCH and DRAIN, 0 in HOLD. imem_addr = pc, held stable while req is high and ack is absent.
- pc+4 wraps mod 2^32; no alignment checking.
- FSM, FETCH:
  - ack & !redirect & !stall: IF/ID <= {1, rdata, pc, pc+4}; pc <= next_pc (sel 0); stay in FETCH. Back-to-back acks give one instruction per cycle.
  - ack & !redirect & stall: skid <= {rdata, pc}; go to HOLD. IF/ID is unchanged.
  - ack & redirect: discard rdata; pc <= next_pc (the target); if_valid <= 0; stay in FETCH.
  - !ack & redirect: saved_target <= selected target; go to DRAIN. The outstanding request must complete first.
- FSM, HOLD:
  - redirect: drop skid; pc <= next_pc; if_valid <= 0; go to FETCH.
  - !stall: IF/ID <= skid (valid); pc <= next_pc (sel 0 = skid pc+4); go to FETCH.
  - Otherwise stay in HOLD.
- FSM, DRAIN:
  - A further redirect overwrites saved_target (newest wins).
  - ack: discard rdata; pc <= next_pc (= saved_target, or the new redirect target if one arrives the same cycle); go to FETCH.
- flush: if_valid <= 0 and skid is dropped. Priority order: flush > stall > load. flush does not change pc. If in HOLD without a redirect, flush goes to FETCH with pc <= skid pc+4.
- stall with no ack: IF/ID holds.
- if_instr = NOP_INSTR whenever if_valid is cleared.
- Latency: ack edge to if_valid = 1 cycle. Redirect to first request at the target = 1 cycle when idle or on ack.

Decomposition:
- Shared package (fetch_pkg):
  - PC_SEL_SEQ = 0, PC_SEL_BR = 1, PC_SEL_JMP = 2, matching the mux encoding.
  - State encoding FETCH/HOLD/DRAIN.
  - RESET_PC and NOP_INSTR defaults.
- Sub-module: if_id_reg, the IF/ID register with load/flush/valid, reused by later stage registers.
- The mux remains an external instance wired at the top level.

Test Plan:
- Reset release, ack every cycle, rdata = 0x11, 0x22, 0x33 -> imem_addr 0x0, 0x4, 0x8; IF/ID (0x11, pc 0x0), (0x22, 0x4), (0x33, 0x8) one cycle after each ack.
- Ack delayed 3 cycles -> imem_addr stays 0x4 with req high; if_valid = 0 until the cycle after ack.
- stall = 1 on the ack at pc 0x8 for 2 cycles -> HOLD, req = 0, IF/ID unchanged. On release, if_instr = skid value with pc 0x8; next address 0xC.
- branch_taken with target 0x100 while request at 0x10 is pending, ack 2 cycles later -> 0x10 data discarded, if_valid = 0, next imem_addr = 0x100.
- jump_taken (0x200) and branch_taken (0x300) in the same cycle as ack -> pc_sel = 2, next imem_addr = 0x200.
- rst_n low mid-DRAIN -> immediately imem_req = 0 and if_valid = 0. After release, the first address is RESET_PC and the saved target is not used.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch stage: next-PC mux selects, FSM states,
// reset defaults and the IF/ID payload.
package fetch_pkg;
  localparam logic [1:0] PC_SEL_SEQ = 2'd0;
  localparam logic [1:0] PC_SEL_BR  = 2'd1;
  localparam logic [1:0] PC_SEL_JMP = 2'd2;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} fetchState_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ifEntry_t;
endpackage

// File: rtl/if_id_reg.sv
// Pipeline register between stages: clear beats load, no load holds.
// An invalid load parks NOP in the instruction slot.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        load,
  input  logic        inValid,
  input  ifEntry_t    inEntry,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      instr   <= NOP_INSTR;
      pc      <= '0;
      pcPlus4 <= '0;
    end else if (clear || (load && !inValid)) begin
      valid   <= 1'b0;
      instr   <= NOP_INSTR;
      pc      <= '0;
      pcPlus4 <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      instr   <= inEntry.instr;
      pc      <= inEntry.pc;
      pcPlus4 <= inEntry.pc + 32'd4;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the external 3-input next-PC mux,
// talks req/ack to instruction memory and fills the IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  input  logic        stall,
  input  logic        flush,
  output logic [1:0]  pc_sel,
  output logic [95:0] pc_cands,
  input  logic [31:0] next_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);
  fetchState_t state, stateNext;
  logic        active;
  logic [31:0] pc, savedTarget, redirTarget;
  ifEntry_t    skid, ifIn;
  logic        redirect, pcLoad, skidLoad, savedLoad, ifClear, ifInValid;

  assign redirect    = jump_taken | branch_taken;
  assign redirTarget = jump_taken ? jump_target : branch_target;
  assign imem_req    = active && (state != HOLD);
  assign imem_addr   = pc;

  // While draining, slot 1 carries the parked target unless a newer redirect arrives.
  assign pc_cands = {jump_target,
                     (state == DRAIN) ? (redirect ? redirTarget : savedTarget) : branch_target,
                     pc + 32'd4};

  always_comb begin
    pc_sel = PC_SEL_SEQ;
    if (state == DRAIN)    pc_sel = PC_SEL_BR;
    else if (jump_taken)   pc_sel = PC_SEL_JMP;
    else if (branch_taken) pc_sel = PC_SEL_BR;
  end

  always_comb begin
    stateNext = state;
    pcLoad    = 1'b0;
    skidLoad  = 1'b0;
    savedLoad = 1'b0;
    ifClear   = flush;
    ifInValid = 1'b0;
    ifIn      = '{instr: imem_rdata, pc: pc};
    if (active) begin
      unique case (state)
        FETCH: begin
          if (imem_ack) begin
            if (redirect) begin
              pcLoad  = 1'b1;
              ifClear = 1'b1;
            end else if (!flush) begin
              if (stall) begin
                skidLoad  = 1'b1;
                stateNext = HOLD;
              end else begin
                pcLoad    = 1'b1;
                ifInValid = 1'b1;
              end
            end
          end else if (redirect) begin
            savedLoad = 1'b1;
            stateNext = DRAIN;
          end
        end
        HOLD: begin
          ifIn = skid;
          // pc still equals the skid pc here, so sel 0 resumes at skid pc+4.
          if (redirect) begin
            pcLoad    = 1'b1;
            ifClear   = 1'b1;
            stateNext = FETCH;
          end else if (flush) begin
            pcLoad    = 1'b1;
            stateNext = FETCH;
          end else if (!stall) begin
            pcLoad    = 1'b1;
            ifInValid = 1'b1;
            stateNext = FETCH;
          end
        end
        DRAIN: begin
          if (redirect) savedLoad = 1'b1;
          if (imem_ack) begin
            pcLoad    = 1'b1;
            stateNext = FETCH;
          end
        end
        default: stateNext = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FETCH;
      active <= 1'b0;
    end else begin
      state  <= stateNext;
      active <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      savedTarget <= '0;
      skid        <= '0;
    end else begin
      if (pcLoad)         pc          <= next_pc;
      if (savedLoad)      savedTarget <= redirTarget;
      if (skidLoad)       skid        <= '{instr: imem_rdata, pc: pc};
      else if (flush)     skid        <= '0;
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) uIfId (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (ifClear),
    .load    (!stall),
    .inValid (ifInValid),
    .inEntry (ifIn),
    .valid   (if_valid),
    .instr   (if_instr),
    .pc      (if_pc),
    .pcPlus4 (if_pc_plus4)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; the bench plays both instruction memory and
// the external next-PC mux, and scores IF/ID contents against a queue.
module tb_fetch_stage;
  logic        clk, rst_n;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        branch_taken, jump_taken, stall, flush;
  logic [31:0] branch_target, jump_target, next_pc;
  logic [1:0]  pc_sel;
  logic [95:0] pc_cands;
  logic        if_valid;
  logic [31:0] if_instr, if_pc, if_pc_plus4;

  typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;
  exp_t sbQ[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic stallAtEdge = 1'b0;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump_taken(jump_taken), .jump_target(jump_target),
    .stall(stall), .flush(flush), .pc_sel(pc_sel), .pc_cands(pc_cands),
    .next_pc(next_pc), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4)
  );

  // External 3-input mux.
  assign next_pc = (pc_sel == 2'd2) ? pc_cands[95:64] :
                   (pc_sel == 2'd1) ? pc_cands[63:32] : pc_cands[31:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    sbQ.push_back(e);
  endtask

  task automatic step(input logic ack, input logic [31:0] rd,
                      input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt,
                      input logic st, input logic fl);
    @(negedge clk);
    imem_ack = ack; imem_rdata = rd;
    branch_taken = br; branch_target = bt;
    jump_taken = jp; jump_target = jt;
    stall = st; flush = fl;
    #1;
  endtask

  always @(posedge clk) stallAtEdge <= stall;

  // A fresh IF/ID entry appears after every edge that was not stalled.
  always @(negedge clk) begin
    if (rst_n && if_valid && !stallAtEdge) begin
      if (sbQ.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL sb_unexpected observed=%h expected=none", if_instr);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        chk("sb_instr", if_instr, e.instr);
        chk("sb_pc", if_pc, e.pc);
        chk("sb_pc_plus4", if_pc_plus4, e.pc + 32'd4);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    imem_ack = 0; imem_rdata = 0; branch_taken = 0; branch_target = 0;
    jump_taken = 0; jump_target = 0; stall = 0; flush = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(if_valid), 0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 0);
    chk("rst_pc4", if_pc_plus4, 0);
    @(negedge clk); rst_n = 1'b1;

    // back-to-back acks
    step(1, 32'h11, 0, 0, 0, 0, 0, 0);
    chk("t1_req", 32'(imem_req), 1); chk("t1_addr0", imem_addr, 32'h0); chk("t1_sel", 32'(pc_sel), 0);
    push(32'h11, 32'h0);
    step(1, 32'h22, 0, 0, 0, 0, 0, 0); chk("t1_addr4", imem_addr, 32'h4); push(32'h22, 32'h4);
    step(1, 32'h33, 0, 0, 0, 0, 0, 0); chk("t1_addr8", imem_addr, 32'h8); push(32'h33, 32'h8);

    // ack delayed three cycles
    step(0, 0, 0, 0, 0, 0, 0, 0); chk("t2_addr", imem_addr, 32'hC);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_addr_hold", imem_addr, 32'hC); chk("t2_req", 32'(imem_req), 1); chk("t2_nvalid", 32'(if_valid), 0);
    step(0, 0, 0, 0, 0, 0, 0, 0); chk("t2_addr_hold2", imem_addr, 32'hC); chk("t2_nvalid2", 32'(if_valid), 0);
    step(1, 32'h44, 0, 0, 0, 0, 0, 0); push(32'h44, 32'hC);

    // stall on ack -> HOLD, then release from skid
    step(1, 32'h55, 0, 0, 0, 0, 1, 0); chk("t3_addr", imem_addr, 32'h10);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("t3_req_hold", 32'(imem_req), 0); chk("t3_instr_held", if_instr, 32'h44);
    chk("t3_pc_held", if_pc, 32'hC); chk("t3_valid_held", 32'(if_valid), 1);
    step(0, 0, 0, 0, 0, 0, 0, 0); chk("t3_req_rel", 32'(imem_req), 0); push(32'h55, 32'h10);
    step(0, 0, 0, 0, 0, 0, 0, 0); chk("t3_addr_next", imem_addr, 32'h14); chk("t3_req_back", 32'(imem_req), 1);

    // branch with request outstanding -> DRAIN
    step(0, 0, 1, 32'h100, 0, 0, 0, 0); chk("t4_sel", 32'(pc_sel), 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_sel_drain", 32'(pc_sel), 1); chk("t4_addr_hold", imem_addr, 32'h14); chk("t4_nvalid", 32'(if_valid), 0);
    step(1, 32'hDEAD, 0, 0, 0, 0, 0, 0); chk("t4_saved", pc_cands[63:32], 32'h100);
    step(0, 0, 0, 0, 0, 0, 0, 0); chk("t4_addr_tgt", imem_addr, 32'h100); chk("t4_nvalid2", 32'(if_valid), 0);

    // jump beats branch on ack
    step(1, 32'hBAD, 1, 32'h300, 1, 32'h200, 0, 0); chk("t5_sel", 32'(pc_sel), 2);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_addr", imem_addr, 32'h200); chk("t5_nvalid", 32'(if_valid), 0); chk("t5_nop", if_instr, 32'h0);

    // newest redirect wins in DRAIN; pc wraps past 2^32
    step(0, 0, 0, 0, 1, 32'hFFFF_FFF0, 0, 0); chk("t6_sel_jmp", 32'(pc_sel), 2);
    step(0, 0, 1, 32'h400, 0, 0, 0, 0); chk("t6_sel_drain", 32'(pc_sel), 1);
    step(0, 0, 0, 0, 0, 0, 0, 0); chk("t6_saved_new", pc_cands[63:32], 32'h400);
    step(1, 32'hCAFE, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    chk("t6_cand_live", pc_cands[63:32], 32'hFFFF_FFFC); chk("t6_sel_live", 32'(pc_sel), 1);
    step(1, 32'h77, 0, 0, 0, 0, 0, 0); chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC); push(32'h77, 32'hFFFF_FFFC);

    // flush in HOLD beats stall, resumes at skid pc+4
    step(1, 32'h88, 0, 0, 0, 0, 1, 0); chk("t7_addr_wrap", imem_addr, 32'h0);
    step(0, 0, 0, 0, 0, 0, 1, 1); chk("t7_req", 32'(imem_req), 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t7_nvalid", 32'(if_valid), 0); chk("t7_nop", if_instr, 32'h0); chk("t7_addr", imem_addr, 32'h4);

    // reset during DRAIN
    step(1, 32'h99, 0, 0, 0, 0, 0, 0); chk("t8_addr", imem_addr, 32'h4); push(32'h99, 32'h4);
    step(0, 0, 1, 32'h500, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0); chk("t8_sel_drain", 32'(pc_sel), 1); chk("t8_valid", 32'(if_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_rst_req", 32'(imem_req), 0); chk("t8_rst_valid", 32'(if_valid), 0); chk("t8_rst_nop", if_instr, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(1, 32'hAA, 0, 0, 0, 0, 0, 0);
    chk("t8_addr_rst", imem_addr, 32'h0); chk("t8_sel_seq", 32'(pc_sel), 0); chk("t8_req", 32'(imem_req), 1);
    push(32'hAA, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 0); chk("t8_addr_next", imem_addr, 32'h4);
    step(0, 0, 0, 0, 0, 0, 0, 0); chk("sb_drained", 32'(sbQ.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
